uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between two byte sources, the arbiter and one UART sender.
// The sender's idle flag rides along so the arbiter sees one bundle.
interface uart_tx_arbiter_if;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_status;
  logic       busy;
  logic       grant_id;
  logic       timeout_err;

  modport master (
    output a_valid, a_data, b_valid, b_data, tx_status,
    input  a_ready, b_ready, tx_data, tx_en, busy,
    input  grant_id, timeout_err
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, tx_status,
    output a_ready, b_ready, tx_data, tx_en, busy,
    output grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-port round-robin byte arbiter feeding a single UART sender.
// Each port has its own small FIFO; one byte is handed over per tx_en.
module uart_tx_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 8192
) (
  input  logic             sysclk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, LOAD, WAIT_BUSY, WAIT_DONE
  } state_t;

  state_t state, state_n;

  logic [7:0]    mem   [2][FIFO_DEPTH];
  logic [AW-1:0] wptr  [2];
  logic [AW-1:0] rptr  [2];
  logic [AW:0]   count [2];
  logic [7:0]    din   [2];
  logic [1:0]    valid, ready, push, pop, filled;

  logic          gnt, pick, start, expire, err;
  logic [7:0]    data;
  logic [TW-1:0] tcnt;

  assign din[0] = bus.a_data;
  assign din[1] = bus.b_data;
  assign valid  = {bus.b_valid, bus.a_valid};

  // ready comes from registered occupancy only, so a full
  // FIFO refuses a push even in its own pop cycle
  assign ready  = {count[1] != FULL, count[0] != FULL};
  assign filled = {count[1] != '0, count[0] != '0};
  assign push   = valid & ready;
  assign pop    = filled & {
    state == LOAD && gnt, state == LOAD && !gnt
  };

  always_ff @(posedge sysclk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          mem[i][wptr[i]] <= din[i];
          wptr[i]         <= wptr[i] + 1'b1;
        end
        if (pop[i])
          rptr[i] <= rptr[i] + 1'b1;
        if (push[i] && !pop[i])
          count[i] <= count[i] + 1'b1;
        else if (pop[i] && !push[i])
          count[i] <= count[i] - 1'b1;
      end
    end
  end

  assign start = (state == IDLE) && (|filled) && bus.tx_status;
  assign pick  = (&filled) ? ~gnt : filled[1];

  always_comb begin
    state_n = state;
    expire  = 1'b0;
    unique case (state)
      IDLE:
        if (start) state_n = LOAD;
      LOAD:
        state_n = WAIT_BUSY;
      WAIT_BUSY:
        if (!bus.tx_status) begin
          state_n = WAIT_DONE;
        end else if (tcnt == LAST) begin
          expire  = 1'b1;
          state_n = IDLE;
        end
      WAIT_DONE:
        if (bus.tx_status) state_n = IDLE;
    endcase
  end

  // byte is latched as LOAD is entered so it is valid under tx_en
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 1'b1;
      data  <= 8'h00;
      tcnt  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        gnt  <= pick;
        data <= mem[pick][rptr[pick]];
      end
      if (state == LOAD)
        tcnt <= '0;
      else if (state == WAIT_BUSY)
        tcnt <= tcnt + 1'b1;
      if (expire)
        err <= 1'b1;
    end
  end

  assign bus.a_ready     = ready[0];
  assign bus.b_ready     = ready[1];
  assign bus.tx_data     = data;
  assign bus.tx_en       = (state == LOAD);
  assign bus.busy        = (state != IDLE);
  assign bus.grant_id    = gnt;
  assign bus.timeout_err = err;
endmodule
